// File: rtl/niu_sio_rsp_rx.sv
// niu_sio_rsp_rx
// NIU-side receiver for the SIO->NIU outbound response path. Each header may
// be followed by four 128-bit payload beats. Every cycle's 16-bit lanes are
// parity checked. A complete response record is queued in a small FIFO that
// the DMA engine drains through valid/ready. Every dequeue is returned to SIO
// as a one-cycle credit pulse.
module niu_sio_rsp_rx #(
  parameter int DEPTH = 4
) (
  input  logic         iol2clk,
  input  logic         rst_l,
  input  logic         sio_niu_hdr_vld,
  input  logic         sio_niu_datareq,
  input  logic [127:0] sio_niu_data,
  input  logic [7:0]   sio_niu_parity,
  output logic         rsp_vld,
  input  logic         rsp_rdy,
  output logic [5:0]   rsp_type,
  output logic [15:0]  rsp_tag,
  output logic         rsp_has_data,
  output logic [511:0] rsp_data,
  output logic         rsp_par_err,
  output logic         niu_sio_dq,
  output logic         ovf_err,
  output logic         proto_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {
    IDLE = 1'b0,
    PLD  = 1'b1
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [1:0]    beat;

  logic [7:0]    lane_par;
  logic          par_bad;
  logic          pop;
  logic          accept;

  // header fields and payload of the response currently being received
  logic          stg_keep;
  logic [5:0]    stg_type;
  logic [15:0]   stg_tag;
  logic          stg_par_err;
  logic [383:0]  stg_data;

  // record written into the FIFO this cycle
  logic          commit;
  logic [5:0]    cm_type;
  logic [15:0]   cm_tag;
  logic          cm_has_data;
  logic [511:0]  cm_data;
  logic          cm_par_err;
  logic          ovf_set;
  logic          proto_set;

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;

  logic [5:0]    mem_type     [DEPTH];
  logic [15:0]   mem_tag      [DEPTH];
  logic          mem_has_data [DEPTH];
  logic [511:0]  mem_data     [DEPTH];
  logic          mem_par_err  [DEPTH];

  // even parity over each 16-bit lane of the incoming cycle
  always_comb begin
    lane_par = '0;
    for (int i = 0; i < 8; i++) begin
      lane_par[i] = ^sio_niu_data[16*i +: 16];
    end
  end

  assign par_bad = |(lane_par ^ sio_niu_parity);
  assign pop     = rsp_vld & rsp_rdy;

  // A slot is reserved only when a header is taken. In IDLE nothing is
  // pending, so a header fits if a slot is free now or is freed by a pop in
  // this same cycle.
  assign accept  = (count < CW'(DEPTH)) || pop;

  // state register
  always_ff @(posedge iol2clk or negedge rst_l) begin
    if (!rst_l) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // next state: a payload phase is walked even for a dropped header so framing holds
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (sio_niu_hdr_vld && sio_niu_datareq) state_nxt = PLD;
      PLD:     if (beat == 2'd3) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs: FIFO commit, the record to commit, and error events
  always_comb begin
    commit      = 1'b0;
    cm_type     = '0;
    cm_tag      = '0;
    cm_has_data = 1'b0;
    cm_data     = '0;
    cm_par_err  = 1'b0;
    ovf_set     = 1'b0;
    proto_set   = 1'b0;
    case (state)
      IDLE: begin
        if (sio_niu_hdr_vld) begin
          ovf_set = !accept;
          if (accept && !sio_niu_datareq) begin
            commit     = 1'b1;
            cm_type    = sio_niu_data[127:122];
            cm_tag     = sio_niu_data[79:64];
            cm_par_err = par_bad;
          end
        end
      end
      PLD: begin
        proto_set = sio_niu_hdr_vld;
        if (beat == 2'd3 && stg_keep) begin
          commit      = 1'b1;
          cm_type     = stg_type;
          cm_tag      = stg_tag;
          cm_has_data = 1'b1;
          cm_data     = {sio_niu_data, stg_data};
          cm_par_err  = stg_par_err | par_bad;
        end
      end
      default: ;
    endcase
  end

  // header capture and payload beat assembly
  always_ff @(posedge iol2clk or negedge rst_l) begin
    if (!rst_l) begin
      beat        <= '0;
      stg_keep    <= 1'b0;
      stg_type    <= '0;
      stg_tag     <= '0;
      stg_par_err <= 1'b0;
      stg_data    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (sio_niu_hdr_vld) begin
            beat        <= 2'd0;
            stg_keep    <= accept;
            stg_type    <= sio_niu_data[127:122];
            stg_tag     <= sio_niu_data[79:64];
            stg_par_err <= par_bad;
          end
        end
        PLD: begin
          beat        <= beat + 2'd1;
          stg_par_err <= stg_par_err | par_bad;
          case (beat)
            2'd0:    stg_data[127:0]   <= sio_niu_data;
            2'd1:    stg_data[255:128] <= sio_niu_data;
            2'd2:    stg_data[383:256] <= sio_niu_data;
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

  // FIFO pointers and occupancy; commit and pop together leave count unchanged
  always_ff @(posedge iol2clk or negedge rst_l) begin
    if (!rst_l) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (commit) wr_ptr <= wr_ptr + AW'(1);
      if (pop)    rd_ptr <= rd_ptr + AW'(1);
      case ({commit, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  // FIFO storage; contents are masked at the outputs whenever the FIFO is empty
  always_ff @(posedge iol2clk) begin
    if (commit) begin
      mem_type[wr_ptr]     <= cm_type;
      mem_tag[wr_ptr]      <= cm_tag;
      mem_has_data[wr_ptr] <= cm_has_data;
      mem_data[wr_ptr]     <= cm_data;
      mem_par_err[wr_ptr]  <= cm_par_err;
    end
  end

  // registered credit pulse and sticky error flags
  always_ff @(posedge iol2clk or negedge rst_l) begin
    if (!rst_l) begin
      niu_sio_dq <= 1'b0;
      ovf_err    <= 1'b0;
      proto_err  <= 1'b0;
    end else begin
      niu_sio_dq <= pop;
      if (ovf_set)   ovf_err   <= 1'b1;
      if (proto_set) proto_err <= 1'b1;
    end
  end

  assign rsp_vld      = (count != '0);
  assign rsp_type     = rsp_vld ? mem_type[rd_ptr]     : '0;
  assign rsp_tag      = rsp_vld ? mem_tag[rd_ptr]      : '0;
  assign rsp_has_data = rsp_vld ? mem_has_data[rd_ptr] : 1'b0;
  assign rsp_data     = rsp_vld ? mem_data[rd_ptr]     : '0;
  assign rsp_par_err  = rsp_vld ? mem_par_err[rd_ptr]  : 1'b0;

endmodule

// File: tb/tb_niu_sio_rsp_rx.sv
// tb_niu_sio_rsp_rx
// Directed vector table, hand-written corner sequences and a randomized run
// for niu_sio_rsp_rx. Each cycle is also compared against a queue-based
// model of the response stream.
module tb_niu_sio_rsp_rx;

  localparam int DEPTH = 4;
  localparam int NVEC  = 17;

  logic         iol2clk;
  logic         rst_l;
  logic         sio_niu_hdr_vld;
  logic         sio_niu_datareq;
  logic [127:0] sio_niu_data;
  logic [7:0]   sio_niu_parity;
  logic         rsp_vld;
  logic         rsp_rdy;
  logic [5:0]   rsp_type;
  logic [15:0]  rsp_tag;
  logic         rsp_has_data;
  logic [511:0] rsp_data;
  logic         rsp_par_err;
  logic         niu_sio_dq;
  logic         ovf_err;
  logic         proto_err;

  niu_sio_rsp_rx #(.DEPTH(DEPTH)) dut (
    .iol2clk         (iol2clk),
    .rst_l           (rst_l),
    .sio_niu_hdr_vld (sio_niu_hdr_vld),
    .sio_niu_datareq (sio_niu_datareq),
    .sio_niu_data    (sio_niu_data),
    .sio_niu_parity  (sio_niu_parity),
    .rsp_vld         (rsp_vld),
    .rsp_rdy         (rsp_rdy),
    .rsp_type        (rsp_type),
    .rsp_tag         (rsp_tag),
    .rsp_has_data    (rsp_has_data),
    .rsp_data        (rsp_data),
    .rsp_par_err     (rsp_par_err),
    .niu_sio_dq      (niu_sio_dq),
    .ovf_err         (ovf_err),
    .proto_err       (proto_err)
  );

  initial iol2clk = 1'b0;
  always #5 iol2clk = ~iol2clk;

  typedef struct packed {
    logic [5:0]   rtype;
    logic [15:0]  tag;
    logic         has;
    logic [511:0] data;
    logic         par;
  } rec_t;

  typedef struct {
    logic         hdr;
    logic         dreq;
    logic [127:0] data;
    logic [7:0]   pflip;
    logic         rdy;
    logic         e_vld;
    logic         e_dq;
    logic [5:0]   e_type;
    logic [15:0]  e_tag;
    logic         e_has;
    logic         e_par;
    logic [127:0] e_lo;
    logic [127:0] e_hi;
  } vec_t;

  int   checks;
  int   errors;

  rec_t m_q[$];
  rec_t m_cur;
  int   m_beats_left;
  logic m_keep;
  logic m_dq;
  logic m_ovf;
  logic m_proto;

  vec_t vecs[NVEC];

  function automatic logic [7:0] gen_par(input logic [127:0] d);
    logic [7:0] p;
    for (int i = 0; i < 8; i++) p[i] = ^d[16*i +: 16];
    return p;
  endfunction

  function automatic logic [127:0] hdr_data(input logic [5:0] t, input logic [15:0] g);
    return {t, 42'h0, g, 64'h0};
  endfunction

  function automatic logic [127:0] rand_data();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic checkOutput(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_cur        = '0;
    m_beats_left = 0;
    m_keep       = 1'b0;
    m_dq         = 1'b0;
    m_ovf        = 1'b0;
    m_proto      = 1'b0;
  endtask

  // one clock edge of the response stream: pop first, then header/beat handling
  task automatic model_step(input logic hdr, input logic dreq, input logic [127:0] d,
                            input logic [7:0] p, input logic rdy);
    logic bad;
    logic pop_now;
    int   idx;
    bad     = (gen_par(d) != p);
    pop_now = (m_q.size() > 0) && rdy;
    if (pop_now) m_q.delete(0);
    m_dq = pop_now;
    if (m_beats_left > 0) begin
      if (hdr) m_proto = 1'b1;
      idx = 4 - m_beats_left;
      m_cur.data[128*idx +: 128] = d;
      m_cur.par = m_cur.par | bad;
      m_beats_left--;
      if (m_beats_left == 0 && m_keep) m_q.push_back(m_cur);
    end else if (hdr) begin
      m_keep = (m_q.size() < DEPTH);
      if (!m_keep) m_ovf = 1'b1;
      m_cur.rtype = d[127:122];
      m_cur.tag   = d[79:64];
      m_cur.has   = dreq;
      m_cur.data  = '0;
      m_cur.par   = bad;
      if (dreq) m_beats_left = 4;
      else if (m_keep) m_q.push_back(m_cur);
    end
  endtask

  task automatic compare_model();
    rec_t e;
    e = '0;
    if (m_q.size() > 0) e = m_q[0];
    checkOutput("m rsp_vld",      512'(rsp_vld),      512'(m_q.size() > 0));
    checkOutput("m rsp_type",     512'(rsp_type),     512'(e.rtype));
    checkOutput("m rsp_tag",      512'(rsp_tag),      512'(e.tag));
    checkOutput("m rsp_has_data", 512'(rsp_has_data), 512'(e.has));
    checkOutput("m rsp_data",     rsp_data,           e.data);
    checkOutput("m rsp_par_err",  512'(rsp_par_err),  512'(e.par));
    checkOutput("m niu_sio_dq",   512'(niu_sio_dq),   512'(m_dq));
    checkOutput("m ovf_err",      512'(ovf_err),      512'(m_ovf));
    checkOutput("m proto_err",    512'(proto_err),    512'(m_proto));
  endtask

  // drive one cycle, clock it, advance the model and compare just after the edge
  task automatic applyStimulus(input logic hdr, input logic dreq, input logic [127:0] d,
                               input logic [7:0] pflip, input logic rdy);
    logic [7:0] p;
    p               = gen_par(d) ^ pflip;
    sio_niu_hdr_vld = hdr;
    sio_niu_datareq = dreq;
    sio_niu_data    = d;
    sio_niu_parity  = p;
    rsp_rdy         = rdy;
    @(posedge iol2clk);
    model_step(hdr, dreq, d, p, rdy);
    #1;
    compare_model();
  endtask

  task automatic do_reset();
    rst_l           = 1'b0;
    sio_niu_hdr_vld = 1'b0;
    sio_niu_datareq = 1'b0;
    sio_niu_data    = '0;
    sio_niu_parity  = '0;
    rsp_rdy         = 1'b0;
    model_reset();
    @(posedge iol2clk);
    #1;
    rst_l = 1'b1;
  endtask

  task automatic send_data_rsp(input logic [5:0] t, input logic [15:0] g, input logic rdy_hdr);
    applyStimulus(1'b1, 1'b1, hdr_data(t, g), 8'h00, rdy_hdr);
    for (int b = 0; b < 4; b++) applyStimulus(1'b0, 1'b0, {g, 112'(b)}, 8'h00, 1'b0);
  endtask

  task automatic drain_check(input string name, input logic [15:0] first, input int n);
    logic [15:0] tags[$];
    int          dq_cnt;
    dq_cnt = 0;
    for (int k = 0; k < n + 4; k++) begin
      if (rsp_vld) tags.push_back(rsp_tag);
      applyStimulus(1'b0, 1'b0, 128'h0, 8'h00, 1'b1);
      if (niu_sio_dq) dq_cnt++;
    end
    checkOutput({name, " pops"}, 512'(tags.size()), 512'(n));
    checkOutput({name, " dq pulses"}, 512'(dq_cnt), 512'(n));
    for (int i = 0; i < tags.size() && i < n; i++)
      checkOutput($sformatf("%s tag%0d", name, i), 512'(tags[i]), 512'(first + 16'(i)));
  endtask

  initial begin
    logic [127:0] h1, h2, h3, h4, pd;
    logic         dr;
    logic [7:0]   fl;
    int           kind;
    int           rdy_pct;

    checks          = 0;
    errors          = 0;
    rst_l           = 1'b1;
    sio_niu_hdr_vld = 1'b0;
    sio_niu_datareq = 1'b0;
    sio_niu_data    = '0;
    sio_niu_parity  = '0;
    rsp_rdy         = 1'b0;
    model_reset();

    // reset state
    #2 rst_l = 1'b0;
    #2;
    checkOutput("reset rsp_vld",      512'(rsp_vld),      512'(0));
    checkOutput("reset niu_sio_dq",   512'(niu_sio_dq),   512'(0));
    checkOutput("reset ovf_err",      512'(ovf_err),      512'(0));
    checkOutput("reset proto_err",    512'(proto_err),    512'(0));
    checkOutput("reset rsp_type",     512'(rsp_type),     512'(0));
    checkOutput("reset rsp_tag",      512'(rsp_tag),      512'(0));
    checkOutput("reset rsp_has_data", 512'(rsp_has_data), 512'(0));
    checkOutput("reset rsp_data",     rsp_data,           512'(0));
    checkOutput("reset rsp_par_err",  512'(rsp_par_err),  512'(0));
    @(posedge iol2clk);
    #1 rst_l = 1'b1;

    // directed vectors: no-data response, data response, parity error, commit+pop
    h1 = hdr_data(6'h2A, 16'h1234);
    h2 = hdr_data(6'h05, 16'hBEEF);
    h3 = hdr_data(6'h11, 16'h0A0A);
    h4 = hdr_data(6'h12, 16'h0B0B);
    vecs[0]  = '{1'b1, 1'b0, h1,       8'h00, 1'b1, 1'b1, 1'b0, 6'h2A, 16'h1234, 1'b0, 1'b0, 128'h0,  128'h0};
    vecs[1]  = '{1'b0, 1'b0, 128'h0,   8'h00, 1'b1, 1'b0, 1'b1, 6'h00, 16'h0000, 1'b0, 1'b0, 128'h0,  128'h0};
    vecs[2]  = '{1'b0, 1'b0, 128'h0,   8'h00, 1'b0, 1'b0, 1'b0, 6'h00, 16'h0000, 1'b0, 1'b0, 128'h0,  128'h0};
    vecs[3]  = '{1'b1, 1'b1, h2,       8'h00, 1'b0, 1'b0, 1'b0, 6'h00, 16'h0000, 1'b0, 1'b0, 128'h0,  128'h0};
    vecs[4]  = '{1'b0, 1'b0, 128'h0,   8'h00, 1'b0, 1'b0, 1'b0, 6'h00, 16'h0000, 1'b0, 1'b0, 128'h0,  128'h0};
    vecs[5]  = '{1'b0, 1'b0, 128'h1,   8'h00, 1'b0, 1'b0, 1'b0, 6'h00, 16'h0000, 1'b0, 1'b0, 128'h0,  128'h0};
    vecs[6]  = '{1'b0, 1'b0, 128'h2,   8'h00, 1'b0, 1'b0, 1'b0, 6'h00, 16'h0000, 1'b0, 1'b0, 128'h0,  128'h0};
    vecs[7]  = '{1'b0, 1'b0, 128'h3,   8'h00, 1'b0, 1'b1, 1'b0, 6'h05, 16'hBEEF, 1'b1, 1'b0, 128'h0,  128'h3};
    vecs[8]  = '{1'b0, 1'b0, 128'h0,   8'h00, 1'b1, 1'b0, 1'b1, 6'h00, 16'h0000, 1'b0, 1'b0, 128'h0,  128'h0};
    vecs[9]  = '{1'b1, 1'b1, h3,       8'h00, 1'b0, 1'b0, 1'b0, 6'h00, 16'h0000, 1'b0, 1'b0, 128'h0,  128'h0};
    vecs[10] = '{1'b0, 1'b0, 128'h10,  8'h00, 1'b0, 1'b0, 1'b0, 6'h00, 16'h0000, 1'b0, 1'b0, 128'h0,  128'h0};
    vecs[11] = '{1'b0, 1'b0, 128'h11,  8'h00, 1'b0, 1'b0, 1'b0, 6'h00, 16'h0000, 1'b0, 1'b0, 128'h0,  128'h0};
    vecs[12] = '{1'b0, 1'b0, 128'h12,  8'h20, 1'b0, 1'b0, 1'b0, 6'h00, 16'h0000, 1'b0, 1'b0, 128'h0,  128'h0};
    vecs[13] = '{1'b0, 1'b0, 128'h13,  8'h00, 1'b0, 1'b1, 1'b0, 6'h11, 16'h0A0A, 1'b1, 1'b1, 128'h10, 128'h13};
    vecs[14] = '{1'b1, 1'b0, h4,       8'h00, 1'b1, 1'b1, 1'b1, 6'h12, 16'h0B0B, 1'b0, 1'b0, 128'h0,  128'h0};
    vecs[15] = '{1'b0, 1'b0, 128'h0,   8'h00, 1'b1, 1'b0, 1'b1, 6'h00, 16'h0000, 1'b0, 1'b0, 128'h0,  128'h0};
    vecs[16] = '{1'b0, 1'b0, 128'h0,   8'h00, 1'b0, 1'b0, 1'b0, 6'h00, 16'h0000, 1'b0, 1'b0, 128'h0,  128'h0};

    for (int r = 0; r < NVEC; r++) begin
      applyStimulus(vecs[r].hdr, vecs[r].dreq, vecs[r].data, vecs[r].pflip, vecs[r].rdy);
      checkOutput($sformatf("row%0d vld", r),  512'(rsp_vld),          512'(vecs[r].e_vld));
      checkOutput($sformatf("row%0d dq", r),   512'(niu_sio_dq),       512'(vecs[r].e_dq));
      checkOutput($sformatf("row%0d type", r), 512'(rsp_type),         512'(vecs[r].e_type));
      checkOutput($sformatf("row%0d tag", r),  512'(rsp_tag),          512'(vecs[r].e_tag));
      checkOutput($sformatf("row%0d has", r),  512'(rsp_has_data),     512'(vecs[r].e_has));
      checkOutput($sformatf("row%0d par", r),  512'(rsp_par_err),      512'(vecs[r].e_par));
      checkOutput($sformatf("row%0d lo", r),   512'(rsp_data[127:0]),  512'(vecs[r].e_lo));
      checkOutput($sformatf("row%0d hi", r),   512'(rsp_data[511:384]), 512'(vecs[r].e_hi));
    end

    // overflow: five data responses into a four-entry FIFO with no consumer
    $display("[TB] overflow sequence");
    do_reset();
    for (int i = 0; i < 5; i++) send_data_rsp(6'h20 + 6'(i), 16'h0100 + 16'(i), 1'b0);
    checkOutput("ovf set", 512'(ovf_err), 512'(1));
    drain_check("ovf drain", 16'h0100, 4);

    // fifth header arrives while the head is being popped, so it fits
    $display("[TB] full boundary with pop");
    do_reset();
    for (int i = 0; i < 4; i++) send_data_rsp(6'h20 + 6'(i), 16'h0100 + 16'(i), 1'b0);
    send_data_rsp(6'h24, 16'h0104, 1'b1);
    checkOutput("boundary ovf clear", 512'(ovf_err), 512'(0));
    drain_check("boundary drain", 16'h0101, 4);

    // header strobe during a payload phase
    $display("[TB] protocol error sequence");
    do_reset();
    pd = hdr_data(6'h3F, 16'hDEAD) | 128'h1;
    applyStimulus(1'b1, 1'b1, hdr_data(6'h07, 16'h0077), 8'h00, 1'b0);
    applyStimulus(1'b0, 1'b0, 128'hA0, 8'h00, 1'b0);
    applyStimulus(1'b1, 1'b0, pd, 8'h00, 1'b0);
    checkOutput("proto set", 512'(proto_err), 512'(1));
    applyStimulus(1'b0, 1'b0, 128'hA2, 8'h00, 1'b0);
    applyStimulus(1'b0, 1'b0, 128'hA3, 8'h00, 1'b0);
    checkOutput("proto entry tag", 512'(rsp_tag), 512'(16'h0077));
    checkOutput("proto entry beat1", 512'(rsp_data[255:128]), 512'(pd));
    drain_check("proto drain", 16'h0077, 1);

    // asynchronous reset in the middle of a payload
    $display("[TB] mid-packet reset sequence");
    applyStimulus(1'b1, 1'b0, hdr_data(6'h01, 16'h0101), 8'h00, 1'b0);
    applyStimulus(1'b1, 1'b1, hdr_data(6'h02, 16'h0202), 8'h00, 1'b0);
    applyStimulus(1'b0, 1'b0, 128'hB0, 8'h00, 1'b0);
    applyStimulus(1'b0, 1'b0, 128'hB1, 8'h00, 1'b0);
    rst_l = 1'b0;
    #1;
    checkOutput("midrst rsp_vld",   512'(rsp_vld),   512'(0));
    checkOutput("midrst proto_err", 512'(proto_err), 512'(0));
    checkOutput("midrst rsp_tag",   512'(rsp_tag),   512'(0));
    checkOutput("midrst rsp_type",  512'(rsp_type),  512'(0));
    model_reset();
    @(posedge iol2clk);
    #1 rst_l = 1'b1;
    applyStimulus(1'b0, 1'b0, 128'hB2, 8'h00, 1'b0);
    applyStimulus(1'b0, 1'b0, 128'hB3, 8'h00, 1'b0);
    checkOutput("midrst no entry", 512'(rsp_vld), 512'(0));
    applyStimulus(1'b1, 1'b0, hdr_data(6'h03, 16'h0303), 8'h00, 1'b0);
    checkOutput("midrst new vld", 512'(rsp_vld), 512'(1));
    checkOutput("midrst new tag", 512'(rsp_tag), 512'(16'h0303));

    // randomized traffic against the model
    $display("[TB] random sequence");
    do_reset();
    for (int t = 0; t < 300; t++) begin
      rdy_pct = (t < 150) ? 25 : 75;
      kind    = int'($urandom_range(0, 9));
      if (kind < 3) begin
        applyStimulus(1'b0, 1'($urandom_range(0, 1)), rand_data(), 8'h00,
                      ($urandom_range(0, 99) < rdy_pct));
      end else begin
        dr = 1'($urandom_range(0, 1));
        fl = ($urandom_range(0, 7) == 0) ? 8'(32'd1 << $urandom_range(0, 7)) : 8'h00;
        applyStimulus(1'b1, dr, rand_data(), fl, ($urandom_range(0, 99) < rdy_pct));
        if (dr) begin
          for (int b = 0; b < 4; b++) begin
            fl = ($urandom_range(0, 9) == 0) ? 8'(32'd1 << $urandom_range(0, 7)) : 8'h00;
            applyStimulus(($urandom_range(0, 15) == 0), 1'($urandom_range(0, 1)), rand_data(),
                          fl, ($urandom_range(0, 99) < rdy_pct));
          end
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
